// File: rtl/mipi_relay_pkg.sv
// Shared types and defaults for the CSI-2 RX to MIPI TX line relay.
// Holds the replay-state encoding and the default timing constants.
package mipi_relay_pkg;

    localparam int unsigned LINE_WORDS_DEF = 1024;
    localparam int unsigned ADDR_W         = $clog2(LINE_WORDS_DEF);
    localparam int unsigned HS_PULSE_DEF   = 4;
    localparam int unsigned HS_BLANK_DEF   = 16;
    localparam int unsigned VS_PULSE_DEF   = 4;
    localparam int unsigned VS_BLANK_DEF   = 32;

    typedef enum logic [2:0] {
        StIdle,
        StVsPulse,
        StVsBlank,
        StHsPulse,
        StHsBlank,
        StData
    } replay_state_e;

endpackage

// File: rtl/mipi_line_relay_if.sv
// Pixel stream bundle used on both the RX capture side and the TX replay side.
// The master drives the stream and the slave receives it.
interface mipi_line_relay_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              hsync;
    logic              vsync;
    logic [5:0]        dtype;

    modport master (output data, valid, hsync, vsync, dtype);
    modport slave  (input  data, valid, hsync, vsync, dtype);
endinterface

// File: rtl/line_ram_dp.sv
// Simple dual-port line RAM: one write port, one registered read port.
// The array itself is never reset.
module line_ram_dp #(
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned DEPTH  = 2048,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/mipi_line_relay.sv
// Captures VC0 lines into a ping-pong buffer and replays them to TX with
// regenerated sync pulses, fixed blanking and a computed horizontal resolution.
module mipi_line_relay
    import mipi_relay_pkg::*;
#(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned LINE_WORDS   = LINE_WORDS_DEF,
    parameter int unsigned HS_PULSE     = HS_PULSE_DEF,
    parameter int unsigned HS_BLANK     = HS_BLANK_DEF,
    parameter int unsigned VS_PULSE     = VS_PULSE_DEF,
    parameter int unsigned VS_BLANK     = VS_BLANK_DEF
) (
    input  logic              PixelClk,
    input  logic              PixelRstN,
    mipi_line_relay_if.slave  rx,
    mipi_line_relay_if.master tx,
    output logic [15:0]       TxHRes,
    output logic [7:0]        LineDrop,
    output logic              OvfErr
);
    localparam int unsigned AW = $clog2(LINE_WORDS);
    localparam int unsigned CW = AW + 1;

    logic hs_q, vs_q, valid_q, hs_rise, vs_rise, valid_fall;
    logic wr_sel_q, rd_sel_q, cap_q, vs_pend_q;
    logic [1:0] full_q, full_d;
    logic [CW-1:0] len_q [2];
    logic [5:0] type_q [2];
    logic [5:0] dtype_q;
    logic [CW-1:0] wr_cnt_q, cnt_base;
    logic [AW-1:0] rd_ptr_q;
    logic line_kept, cap_eff, wr_en, ovf_hit, commit, drop;
    logic release_line, load_hdr, take_vs, reading, tx_valid, tx_hsync, tx_vsync;
    logic [AW:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    replay_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    assign hs_rise    = rx.hsync & ~hs_q;
    assign vs_rise    = rx.vsync & ~vs_q;
    assign valid_fall = ~rx.valid & valid_q;

    // A bank released by the reader this cycle counts as free for a new line.
    always_comb begin
        line_kept = ~(full_q[wr_sel_q] & ~(release_line & (rd_sel_q == wr_sel_q)));
        cap_eff   = hs_rise ? line_kept : cap_q;
        cnt_base  = hs_rise ? '0 : wr_cnt_q;
        wr_en     = cap_eff & rx.valid & ~vs_rise & (cnt_base < CW'(LINE_WORDS));
        ovf_hit   = cap_eff & rx.valid & ~vs_rise & ~(cnt_base < CW'(LINE_WORDS));
        commit    = cap_q & valid_fall & (wr_cnt_q != '0) & ~vs_rise & ~hs_rise;
        drop      = hs_rise & ~line_kept & ~vs_rise;
        full_d    = full_q;
        if (release_line) full_d[rd_sel_q] = 1'b0;
        if (commit) full_d[wr_sel_q] = 1'b1;
        if (vs_rise) begin
            for (int b = 0; b < 2; b++) begin
                if (!(reading && (rd_sel_q == 1'(b)))) full_d[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge PixelClk) begin
        if (!PixelRstN) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            valid_q   <= 1'b0;
            cap_q     <= 1'b0;
            wr_cnt_q  <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            full_q    <= '0;
            vs_pend_q <= 1'b0;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            type_q[0] <= '0;
            type_q[1] <= '0;
            dtype_q   <= '0;
            rd_ptr_q  <= '0;
            TxHRes    <= '0;
            LineDrop  <= '0;
            OvfErr    <= 1'b0;
        end else begin
            hs_q    <= rx.hsync;
            vs_q    <= rx.vsync;
            valid_q <= rx.valid;
            cap_q   <= (vs_rise || commit) ? 1'b0 : cap_eff;
            if (hs_rise) wr_cnt_q <= wr_en ? CW'(1) : '0;
            else if (wr_en) wr_cnt_q <= wr_cnt_q + CW'(1);
            if (hs_rise && line_kept) type_q[wr_sel_q] <= rx.dtype;
            if (commit) len_q[wr_sel_q] <= wr_cnt_q;
            full_q <= full_d;
            // Resync the writer to the bank after the reader so the ping-pong order survives a flush.
            if (vs_rise) wr_sel_q <= reading ? ~rd_sel_q : rd_sel_q;
            else if (commit) wr_sel_q <= ~wr_sel_q;
            if (release_line) rd_sel_q <= ~rd_sel_q;
            vs_pend_q <= (vs_pend_q & ~take_vs) | vs_rise;
            if (drop && (LineDrop != 8'hFF)) LineDrop <= LineDrop + 8'd1;
            if (ovf_hit) OvfErr <= 1'b1;
            if (load_hdr) begin
                TxHRes  <= 16'(32'(len_q[rd_sel_q]) * PIX_PER_WORD);
                dtype_q <= type_q[rd_sel_q];
            end
            rd_ptr_q <= (state_q == StData) ? rd_ptr_q + AW'(1) : AW'(1);
        end
    end

    always_ff @(posedge PixelClk) begin
        if (!PixelRstN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
        unique case (state_q)
            StIdle: begin
                if (vs_pend_q) begin
                    state_d = StVsPulse;
                    cnt_d   = 16'(VS_PULSE - 1);
                end else if (full_q[rd_sel_q] && !vs_rise) begin
                    state_d = StHsPulse;
                    cnt_d   = 16'(HS_PULSE - 1);
                end
            end
            StVsPulse: if (cnt_q == '0) begin
                state_d = StVsBlank;
                cnt_d   = 16'(VS_BLANK - 1);
            end
            StVsBlank: if (cnt_q == '0) state_d = StIdle;
            StHsPulse: if (cnt_q == '0) begin
                state_d = StHsBlank;
                cnt_d   = 16'(HS_BLANK - 1);
            end
            StHsBlank: if (cnt_q == '0) begin
                state_d = StData;
                cnt_d   = 16'(len_q[rd_sel_q]) - 16'd1;
            end
            StData: if (cnt_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_vsync     = (state_q == StVsPulse);
        tx_hsync     = (state_q == StHsPulse);
        tx_valid     = (state_q == StData);
        reading      = (state_q == StHsPulse) || (state_q == StHsBlank) || (state_q == StData);
        release_line = (state_q == StData) && (cnt_q == '0);
        take_vs      = (state_q == StIdle) && vs_pend_q;
        load_hdr     = (state_q == StIdle) && !vs_pend_q && full_q[rd_sel_q] && !vs_rise;
        // Word 0 is addressed during blanking so data is ready on the first DATA cycle.
        rd_addr      = {rd_sel_q, (state_q == StData) ? rd_ptr_q : AW'(0)};
    end

    line_ram_dp #(
        .DATA_W(DATA_W),
        .DEPTH (2 * LINE_WORDS)
    ) u_ram (
        .clk  (PixelClk),
        .we   (wr_en),
        .waddr({wr_sel_q, cnt_base[AW-1:0]}),
        .wdata(rx.data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    assign tx.data  = tx_valid ? rd_data : '0;
    assign tx.valid = tx_valid;
    assign tx.hsync = tx_hsync;
    assign tx.vsync = tx_vsync;
    assign tx.dtype = dtype_q;
endmodule

// File: tb/tb_mipi_line_relay.sv
// Scoreboard bench for mipi_line_relay: expected words and line headers are
// queued as RX lines are driven and popped by a TX monitor.
module tb_mipi_line_relay;
    typedef struct {
        logic [15:0] hres;
        logic [5:0]  dtype;
        int          words;
    } line_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [15:0] hres;
    logic [7:0] line_drop;
    logic ovf;

    mipi_line_relay_if #(.DATA_W(64)) rx_if ();
    mipi_line_relay_if #(.DATA_W(64)) tx_if ();

    mipi_line_relay dut (
        .PixelClk (clk),
        .PixelRstN(rstn),
        .rx       (rx_if),
        .tx       (tx_if),
        .TxHRes   (hres),
        .LineDrop (line_drop),
        .OvfErr   (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_data[$];
    line_t exp_lines[$];

    // Monitor state
    int  lines_seen = 0, vs_seen = 0, vs_line_mark = 0;
    int  hs_cnt = 0, vs_cnt = 0, blank = 0, words = 0, cur_words = -1;
    bit  p_hs = 0, p_vs = 0, p_valid = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            hs_cnt = 0; vs_cnt = 0; blank = 0; words = 0; cur_words = -1;
            p_hs = 0; p_vs = 0; p_valid = 0;
        end else begin
            if (tx_if.vsync) vs_cnt++;
            if (tx_if.vsync && !p_vs) vs_line_mark = lines_seen;
            if (p_vs && !tx_if.vsync) begin
                checks++;
                if (vs_cnt !== 4) begin
                    errors++; $display("FAIL vs_width: got %0d cycles, want 4", vs_cnt);
                end
                vs_cnt = 0; vs_seen++;
            end
            if (tx_if.hsync) hs_cnt++;
            if (tx_if.hsync && !p_hs) begin
                line_t e;
                checks++;
                if (exp_lines.size() == 0) begin
                    errors++; $display("FAIL line_start: unexpected TX line, hres=%0d", hres);
                    cur_words = -1;
                end else begin
                    e = exp_lines.pop_front();
                    cur_words = e.words;
                    if (hres !== e.hres || tx_if.dtype !== e.dtype) begin
                        errors++;
                        $display("FAIL line_hdr: hres=%0d type=%h, want hres=%0d type=%h",
                                 hres, tx_if.dtype, e.hres, e.dtype);
                    end
                end
                words = 0;
            end
            if (p_hs && !tx_if.hsync) begin
                checks++;
                if (hs_cnt !== 4) begin
                    errors++; $display("FAIL hs_width: got %0d cycles, want 4", hs_cnt);
                end
                hs_cnt = 0; blank = 1;
            end else if (blank > 0 && !tx_if.valid) begin
                blank++;
            end
            if (tx_if.valid && !p_valid) begin
                checks++;
                if (blank !== 16) begin
                    errors++; $display("FAIL hs_blank: got %0d cycles, want 16", blank);
                end
                blank = 0;
            end
            if (tx_if.valid) begin
                logic [63:0] w;
                checks++;
                if (exp_data.size() == 0) begin
                    errors++; $display("FAIL tx_data: unexpected word %h", tx_if.data);
                end else begin
                    w = exp_data.pop_front();
                    if (tx_if.data !== w) begin
                        errors++; $display("FAIL tx_data: got %h want %h", tx_if.data, w);
                    end
                end
                words++;
            end
            if (p_valid && !tx_if.valid) begin
                checks++;
                if (words !== cur_words) begin
                    errors++; $display("FAIL line_len: got %0d words, want %0d", words, cur_words);
                end
                lines_seen++;
            end
            p_hs = tx_if.hsync; p_vs = tx_if.vsync; p_valid = tx_if.valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vsync();
        rx_if.vsync = 1'b1;
        tick(); tick();
        rx_if.vsync = 1'b0;
        tick();
    endtask

    task automatic send_line(input int n, input logic [5:0] dt, input bit keep);
        line_t e;
        logic [63:0] w;
        int kept_n;
        kept_n = (n > 1024) ? 1024 : n;
        if (keep) begin
            e.hres = 16'(kept_n * 4); e.dtype = dt; e.words = kept_n;
            exp_lines.push_back(e);
        end
        rx_if.hsync = 1'b1; rx_if.dtype = dt;
        tick();
        rx_if.hsync = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = {$urandom(), $urandom()};
            rx_if.data = w; rx_if.valid = 1'b1;
            if (keep && i < 1024) exp_data.push_back(w);
            tick();
        end
        rx_if.valid = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_data.size() != 0 || exp_lines.size() != 0) && n < 5000) begin
            tick(); n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL %s_drain: %0d words %0d lines outstanding, want 0", name,
                     exp_data.size(), exp_lines.size());
            exp_data.delete(); exp_lines.delete();
        end
        repeat (45) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_if.valid, tx_if.hsync, tx_if.vsync, tx_if.dtype} !== 9'd0) begin
            errors++; $display("FAIL reset_ctrl: v/hs/vs/type=%b, want 0",
                               {tx_if.valid, tx_if.hsync, tx_if.vsync, tx_if.dtype});
        end
        checks++;
        if (tx_if.data !== 64'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0", tx_if.data);
        end
        checks++;
        if ({hres, line_drop, ovf} !== 25'd0) begin
            errors++; $display("FAIL reset_status: hres=%0d drop=%0d ovf=%b, want 0",
                               hres, line_drop, ovf);
        end
        tick();
    endtask

    task automatic test_frame();
        int l0 = lines_seen, v0 = vs_seen;
        send_vsync();
        send_line(480, 6'h2B, 1'b1);
        drain("frame");
        checks++;
        if (vs_seen - v0 !== 1 || lines_seen - l0 !== 1) begin
            errors++; $display("FAIL frame_counts: vs=%0d lines=%0d, want 1 and 1",
                               vs_seen - v0, lines_seen - l0);
        end
        checks++;
        if (hres !== 16'd1920) begin
            errors++; $display("FAIL frame_hres: got %0d want 1920", hres);
        end
    endtask

    task automatic test_back_to_back();
        int l0 = lines_seen;
        send_line(100, 6'h2A, 1'b1);
        repeat (10) tick();
        send_line(200, 6'h2C, 1'b1);
        drain("b2b");
        checks++;
        if (lines_seen - l0 !== 2 || line_drop !== 8'd0) begin
            errors++; $display("FAIL b2b_counts: lines=%0d drop=%0d, want 2 and 0",
                               lines_seen - l0, line_drop);
        end
    endtask

    task automatic test_drop();
        int l0 = lines_seen;
        send_line(20, 6'h1E, 1'b1);
        tick();
        send_line(20, 6'h1F, 1'b1);
        tick();
        send_line(20, 6'h12, 1'b0);
        drain("drop");
        checks++;
        if (line_drop !== 8'd1) begin
            errors++; $display("FAIL drop_count: got %0d want 1", line_drop);
        end
        checks++;
        if (lines_seen - l0 !== 2) begin
            errors++; $display("FAIL drop_lines: got %0d want 2", lines_seen - l0);
        end
    endtask

    task automatic test_overflow();
        send_line(1030, 6'h2B, 1'b1);
        drain("ovf");
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_flag: got %b want 1", ovf);
        end
        checks++;
        if (hres !== 16'd4096) begin
            errors++; $display("FAIL ovf_hres: got %0d want 4096", hres);
        end
    endtask

    task automatic test_flush();
        int l0 = lines_seen, v0 = vs_seen;
        send_line(300, 6'h2B, 1'b1);
        repeat (5) tick();
        send_line(40, 6'h2A, 1'b0);
        repeat (10) tick();
        send_vsync();
        drain("flush");
        checks++;
        if (lines_seen - l0 !== 1 || vs_seen - v0 !== 1) begin
            errors++; $display("FAIL flush_counts: lines=%0d vs=%0d, want 1 and 1",
                               lines_seen - l0, vs_seen - v0);
        end
        checks++;
        if (vs_line_mark !== l0 + 1) begin
            errors++; $display("FAIL flush_order: vsync after %0d lines, want %0d",
                               vs_line_mark, l0 + 1);
        end
        checks++;
        if (line_drop !== 8'd1) begin
            errors++; $display("FAIL flush_drop: got %0d want 1", line_drop);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, l0;
        send_line(200, 6'h2B, 1'b1);
        while (!tx_if.valid && n < 600) begin
            tick(); n++;
        end
        checks++;
        if (n >= 600) begin
            errors++; $display("FAIL rstmid_wait: TxValid never rose, want 1");
        end
        repeat (20) tick();
        rstn = 1'b0;
        exp_data.delete(); exp_lines.delete();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_if.valid, tx_if.hsync, tx_if.vsync, tx_if.dtype, hres, line_drop, ovf} !== 34'd0
            || tx_if.data !== 64'd0) begin
            errors++;
            $display("FAIL rstmid_out: v=%b hs=%b vs=%b type=%h hres=%0d drop=%0d ovf=%b data=%h, want 0",
                     tx_if.valid, tx_if.hsync, tx_if.vsync, tx_if.dtype, hres, line_drop, ovf,
                     tx_if.data);
        end
        tick();
        l0 = lines_seen;
        send_vsync();
        send_line(64, 6'h24, 1'b1);
        drain("rstmid");
        checks++;
        if (lines_seen - l0 !== 1 || hres !== 16'd256) begin
            errors++; $display("FAIL rstmid_frame: lines=%0d hres=%0d, want 1 and 256",
                               lines_seen - l0, hres);
        end
    endtask

    initial begin
        rx_if.data = '0; rx_if.valid = 1'b0; rx_if.hsync = 1'b0;
        rx_if.vsync = 1'b0; rx_if.dtype = '0;
        test_reset();
        test_frame();
        test_back_to_back();
        test_drop();
        test_overflow();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
